// File: rtl/latch_exerciser_pkg.sv
// Shared definitions for the latch exerciser: FSM encodings, sweep geometry
// and the expected-q table used by both the RTL and the bench.
package latch_exerciser_pkg;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Bit k holds the expected q after vector k; INIT always leaves q at 0.
    localparam logic               INIT_EXP_Q  = 1'b0;
    localparam logic [NUM_VEC-1:0] EXP_Q_TABLE = 8'b0010_0000;

    typedef struct packed {
        logic enable;
        logic reset;
        logic d;
    } lat_drive_t;

    function automatic lat_drive_t vec_drive(input logic [VEC_W-1:0] k);
        return lat_drive_t'(k);
    endfunction

endpackage

// File: rtl/latch_exerciser_if.sv
// Connection between the exerciser (master) and the latch under test (slave).
interface latch_exerciser_if;

    logic lat_d;
    logic lat_enable;
    logic lat_reset;
    logic lat_q;
    logic lat_q_not;

    modport master (
        output lat_d, lat_enable, lat_reset,
        input  lat_q, lat_q_not
    );

    modport slave (
        input  lat_d, lat_enable, lat_reset,
        output lat_q, lat_q_not
    );

endinterface

// File: rtl/latch_exerciser_ref_model.sv
// Clocked reference model of a D latch with reset: applies one vector per
// update strobe, reset taking priority over enable.
module latch_ref_model (
    input  logic clk,
    input  logic reset_n,
    input  logic update,
    input  logic enable,
    input  logic reset,
    input  logic d,
    input  logic init,
    output logic exp_q
);
    import latch_exerciser_pkg::*;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q <= 1'b0;
        end else if (update) begin
            if (init)
                exp_q <= INIT_EXP_Q;
            else if (reset)
                exp_q <= 1'b0;
            else if (enable)
                exp_q <= d;
        end
    end

endmodule

// File: rtl/latch_exerciser.sv
// Drives a D latch through init plus all eight {enable, reset, d} vectors,
// each held H cycles, and counts mismatches against the reference model.
module latch_exerciser
    import latch_exerciser_pkg::*;
#(
    parameter int HOLD_W = 4,
    parameter int ERR_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [HOLD_W-1:0]     hold_cycles,
    latch_exerciser_if.master     lat,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [VEC_W-1:0]      vec_idx
);

    state_e              state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   cnt_q;
    logic [HOLD_W-1:0]   hold_m1;
    logic [VEC_W-1:0]    next_vec;
    lat_drive_t          next_drive;
    logic                exp_q;
    logic                at_check;
    logic                last_vec;
    logic                check_fail;
    logic                model_update;
    logic [ERR_W-1:0]    err_next;

    // Counter reloads with H-1, so a hold of 0 behaves like 1.
    assign hold_m1    = (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;
    assign at_check   = ((state_q == ST_INIT) || (state_q == ST_SWEEP)) && (cnt_q == '0);
    assign last_vec   = (state_q == ST_SWEEP) && (vec_idx == VEC_W'(NUM_VEC - 1));
    assign next_vec   = (state_q == ST_INIT) ? '0 : vec_idx + 1'b1;
    assign next_drive = vec_drive(next_vec);
    assign check_fail = (lat.lat_q != exp_q) || (lat.lat_q_not != ~exp_q);
    assign err_next   = (at_check && check_fail && (err_count != '1)) ? err_count + 1'b1
                                                                      : err_count;

    // Model advances whenever a new vector is loaded onto lat_*.
    assign model_update = ((state_q == ST_IDLE) && start) || (at_check && !last_vec);

    latch_ref_model u_ref (
        .clk     (clk),
        .reset_n (reset_n),
        .update  (model_update),
        .enable  (next_drive.enable),
        .reset   (next_drive.reset),
        .d       (next_drive.d),
        .init    (state_q == ST_IDLE),
        .exp_q   (exp_q)
    );

    // NOTE: every register here uses <= so all branches see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            hold_q         <= '0;
            cnt_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            vec_idx        <= '0;
            lat.lat_d      <= 1'b0;
            lat.lat_enable <= 1'b0;
            lat.lat_reset  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q        <= ST_INIT;
                        hold_q         <= hold_m1;
                        cnt_q          <= hold_m1;
                        busy           <= 1'b1;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        vec_idx        <= '0;
                        lat.lat_d      <= 1'b0;
                        lat.lat_enable <= 1'b0;
                        lat.lat_reset  <= 1'b1;
                    end
                end
                ST_INIT, ST_SWEEP: begin
                    err_count <= err_next;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (last_vec) begin
                        state_q        <= ST_DONE;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        pass           <= (err_next == '0);
                        lat.lat_d      <= 1'b0;
                        lat.lat_enable <= 1'b0;
                        lat.lat_reset  <= 1'b0;
                    end else begin
                        state_q        <= ST_SWEEP;
                        cnt_q          <= hold_q;
                        vec_idx        <= next_vec;
                        lat.lat_d      <= next_drive.d;
                        lat.lat_enable <= next_drive.enable;
                        lat.lat_reset  <= next_drive.reset;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
